// File: rtl/inst_sram_like_slave_pkg.sv
// Shared constants and helpers for the inst_sram slave bridge.
//   SIZE_*       : encodings of the request size field (3 is treated as word)
//   LFSR_*       : width and tap mask of the handshake-jitter LFSR
//   CNT_W        : width of the saturating handshake delay counters
//   lfsr_next()  : one Fibonacci step, taps 16,14,13,11
//   wen_decode() : byte-lane write enables from size and addr[1:0]
package inst_sram_like_slave_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  localparam int LFSR_W = 16;
  // Taps 16,14,13,11 counted from 1 map to bits 15,13,12,10.
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

  localparam int CNT_W = 16;

  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
    return {s[LFSR_W-2:0], ^(s & LFSR_TAPS)};
  endfunction

  function automatic logic [3:0] wen_decode(input logic [1:0] size, input logic [1:0] lane);
    logic [3:0] wen;
    case (size)
      SIZE_BYTE: wen = 4'b0001 << lane;
      SIZE_HALF: wen = 4'b0011 << {lane[1], 1'b0};
      default:   wen = 4'hF;
    endcase
    return wen;
  endfunction

endpackage

// File: rtl/sram_resp_fifo.sv
// In-order response queue for the inst_sram slave.
// Each entry holds {wr, data_valid, data}. An entry is pushed at the address
// handshake with data_valid=0; on the following cycle the RAM read data is
// captured into that same entry (writes store 0) and data_valid is set.
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   push, push_wr         : allocate tail entry, record read/write
//   capture, capture_data : fill the most recently pushed entry
//   pop                   : retire the head entry
//   count                 : occupancy
//   head_valid, head_data_valid, head_data : head entry view
module sram_resp_fifo #(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             push_wr,
  input  logic             capture,
  input  logic [31:0]      capture_data,
  input  logic             pop,
  output logic [CNT_W-1:0] count,
  output logic             head_valid,
  output logic             head_data_valid,
  output logic [31:0]      head_data
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] head_ptr;
  logic [PTR_W-1:0] tail_ptr;
  logic [PTR_W-1:0] cap_ptr;
  logic             wr_q   [DEPTH];
  logic             dv_q   [DEPTH];
  logic [31:0]      data_q [DEPTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      cap_ptr  <= '0;
      count    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        wr_q[i]   <= 1'b0;
        dv_q[i]   <= 1'b0;
        data_q[i] <= '0;
      end
    end else begin
      if (push) begin
        wr_q[tail_ptr] <= push_wr;
        dv_q[tail_ptr] <= 1'b0;
        cap_ptr        <= tail_ptr;
        tail_ptr       <= tail_ptr + 1'b1;
      end
      // cap_ptr is the entry pushed last cycle; it never equals the current
      // tail, so capture and a new push never collide.
      if (capture) begin
        dv_q[cap_ptr]   <= 1'b1;
        data_q[cap_ptr] <= wr_q[cap_ptr] ? 32'h0 : capture_data;
      end
      if (pop) begin
        head_ptr <= head_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head_valid      = (count != '0);
  assign head_data_valid = dv_q[head_ptr];
  assign head_data       = data_q[head_ptr];

endmodule

// File: rtl/inst_sram_like_slave.sv
// Slave end of the inst_sram req/addr_ok/data_ok protocol, bridging to a
// synchronous RAM with one cycle of read latency. Responses are in order.
//
// Handshake semantics: a request is accepted in any cycle where req and
// addr_ok are both high; the request fields are sampled only then. data_ok is
// a single-cycle pulse per accepted request with no back-pressure, so the
// initiator must consume rdata in that cycle.
//
// Ports:
//   clk, reset           : clock, synchronous active-high reset
//   req, wr, size, addr, wdata : request from initiator
//   addr_ok              : request accepted this cycle (with req)
//   rdata, data_ok       : response data and its strobe
//   ram_en, ram_wen, ram_addr, ram_wdata, ram_rdata : RAM port
//   outstanding          : accepted but not yet returned requests
module inst_sram_like_slave
  import inst_sram_like_slave_pkg::*;
#(
  parameter int                DEPTH         = 4,
  parameter int                ADDR_OK_DELAY = 0,
  parameter int                DATA_OK_DELAY = 0,
  parameter int                RAND_EN       = 0,
  parameter logic [LFSR_W-1:0] LFSR_SEED     = 16'hACE1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       req,
  input  logic                       wr,
  input  logic [1:0]                 size,
  input  logic [31:0]                addr,
  input  logic [31:0]                wdata,
  output logic                       addr_ok,
  output logic [31:0]                rdata,
  output logic                       data_ok,
  output logic                       ram_en,
  output logic [3:0]                 ram_wen,
  output logic [31:0]                ram_addr,
  output logic [31:0]                ram_wdata,
  input  logic [31:0]                ram_rdata,
  output logic [$clog2(DEPTH):0]     outstanding
);

  localparam int OCC_W = $clog2(DEPTH) + 1;

  logic [OCC_W-1:0]  count;
  logic              head_valid;
  logic              head_dv;
  logic [31:0]       head_data;
  logic [CNT_W-1:0]  acnt;
  logic [CNT_W-1:0]  dcnt;
  logic [LFSR_W-1:0] lfsr;
  logic              cap_q;
  logic              hs;
  logic              room;
  logic              addr_jitter_ok;
  logic              data_jitter_ok;

  // Occupancy is the registered count, so a pop in this cycle does not make
  // room for an accept in the same cycle.
  assign room           = (count < OCC_W'(DEPTH));
  assign addr_jitter_ok = (RAND_EN == 0) || lfsr[0];
  assign data_jitter_ok = (RAND_EN == 0) || lfsr[1];

  assign addr_ok = !reset && req && room &&
                   (acnt >= CNT_W'(ADDR_OK_DELAY)) && addr_jitter_ok;
  assign hs      = req && addr_ok;

  assign data_ok = !reset && head_valid && head_dv &&
                   (dcnt >= CNT_W'(DATA_OK_DELAY)) && data_jitter_ok;
  assign rdata   = data_ok ? head_data : 32'h0;

  // RAM is strobed combinationally from the handshake so its data lands one
  // cycle later, in time for the capture into the queue entry.
  assign ram_en    = hs;
  assign ram_wen   = (hs && wr) ? wen_decode(size, addr[1:0]) : 4'h0;
  assign ram_addr  = {addr[31:2], 2'b00};
  assign ram_wdata = wdata;

  assign outstanding = count;

  always_ff @(posedge clk) begin
    if (reset) begin
      acnt  <= '0;
      dcnt  <= '0;
      lfsr  <= LFSR_SEED;
      cap_q <= 1'b0;
    end else begin
      lfsr  <= lfsr_next(lfsr);
      cap_q <= hs;
      // acnt keeps counting while full; it only restarts on accept or idle.
      if (!req || hs) begin
        acnt <= '0;
      end else if (acnt != '1) begin
        acnt <= acnt + 1'b1;
      end
      if (data_ok) begin
        dcnt <= '0;
      end else if (head_valid && head_dv && (dcnt != '1)) begin
        dcnt <= dcnt + 1'b1;
      end
    end
  end

  sram_resp_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk             (clk),
    .reset           (reset),
    .push            (hs),
    .push_wr         (wr),
    .capture         (cap_q),
    .capture_data    (ram_rdata),
    .pop             (data_ok),
    .count           (count),
    .head_valid      (head_valid),
    .head_data_valid (head_dv),
    .head_data       (head_data)
  );

endmodule

// File: tb/tb_inst_sram_like_slave.sv
// Bench for inst_sram_like_slave. Four instances with different parameters
// share one clock/reset and one RAM model; only one instance is driven at a
// time, so a single expected-response queue serves all of them.
//   dut 0: defaults (DEPTH 4)
//   dut 1: DEPTH 2, DATA_OK_DELAY 3
//   dut 2: ADDR_OK_DELAY 2
//   dut 3: RAND_EN 1
`timescale 1ns/1ps
module tb_inst_sram_like_slave;

  localparam int N = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT signals ----------------
  logic        req_v        [N];
  logic        wr_v         [N];
  logic [1:0]  size_v       [N];
  logic [31:0] addr_v       [N];
  logic [31:0] wdata_v      [N];
  logic        addr_ok_v    [N];
  logic [31:0] rdata_v      [N];
  logic        data_ok_v    [N];
  logic        ram_en_v     [N];
  logic [3:0]  ram_wen_v    [N];
  logic [31:0] ram_addr_v   [N];
  logic [31:0] ram_wdata_v  [N];
  logic [31:0] ram_rdata_v  [N];
  logic [2:0]  outstanding_v[N];

  for (genvar g = 0; g < N; g++) begin : g_dut
    if (g == 1) begin : g_small
      logic [1:0] occ;
      inst_sram_like_slave #(
        .DEPTH         (2),
        .DATA_OK_DELAY (3)
      ) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req_v[g]),
        .wr          (wr_v[g]),
        .size        (size_v[g]),
        .addr        (addr_v[g]),
        .wdata       (wdata_v[g]),
        .addr_ok     (addr_ok_v[g]),
        .rdata       (rdata_v[g]),
        .data_ok     (data_ok_v[g]),
        .ram_en      (ram_en_v[g]),
        .ram_wen     (ram_wen_v[g]),
        .ram_addr    (ram_addr_v[g]),
        .ram_wdata   (ram_wdata_v[g]),
        .ram_rdata   (ram_rdata_v[g]),
        .outstanding (occ)
      );
      assign outstanding_v[g] = {1'b0, occ};
    end else begin : g_std
      inst_sram_like_slave #(
        .DEPTH         (4),
        .ADDR_OK_DELAY ((g == 2) ? 2 : 0),
        .RAND_EN       ((g == 3) ? 1 : 0)
      ) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req_v[g]),
        .wr          (wr_v[g]),
        .size        (size_v[g]),
        .addr        (addr_v[g]),
        .wdata       (wdata_v[g]),
        .addr_ok     (addr_ok_v[g]),
        .rdata       (rdata_v[g]),
        .data_ok     (data_ok_v[g]),
        .ram_en      (ram_en_v[g]),
        .ram_wen     (ram_wen_v[g]),
        .ram_addr    (ram_addr_v[g]),
        .ram_wdata   (ram_wdata_v[g]),
        .ram_rdata   (ram_rdata_v[g]),
        .outstanding (outstanding_v[g])
      );
    end
  end

  // ---------------- RAM model ----------------
  // Background contents: a fixed pattern of the byte address, with the
  // instruction word 0x24080001 at 0x1000.
  function automatic logic [31:0] pat(input logic [31:0] a);
    if (a[15:2] == 14'h400) return 32'h24080001;
    return {a[15:0] ^ 16'h9E37, a[15:0]};
  endfunction

  logic [31:0] mem [0:16383];
  bit          ram_ready = 1'b0;

  always @(posedge clk) begin
    if (!ram_ready) begin
      for (int i = 0; i < 16384; i++) mem[i] <= pat(32'(i) << 2);
      ram_ready <= 1'b1;
    end else begin
      for (int g = 0; g < N; g++) begin
        if (ram_en_v[g]) begin
          for (int b = 0; b < 4; b++)
            if (ram_wen_v[g][b]) mem[ram_addr_v[g][15:2]][b*8 +: 8] <= ram_wdata_v[g][b*8 +: 8];
          ram_rdata_v[g] <= mem[ram_addr_v[g][15:2]];
        end
      end
    end
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Scoreboard: expected rdata and expected data_ok cycle (-1 = not fixed).
  logic [31:0] exp_q[$];
  int          exp_cyc_q[$];
  logic [31:0] mon_exp;
  int          mon_cyc;
  logic        track_occ = 1'b0;
  int          max_occ;

  always @(negedge clk) begin
    for (int g = 0; g < N; g++) begin
      if (data_ok_v[g] === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_data_ok: dut %0d rdata 0x%08h with nothing outstanding (cycle %0d)",
                   g, rdata_v[g], cyc);
        end else begin
          mon_exp = exp_q.pop_front();
          mon_cyc = exp_cyc_q.pop_front();
          check($sformatf("rdata[%0d]", g), rdata_v[g], mon_exp);
          if (mon_cyc >= 0) check($sformatf("data_ok_cycle[%0d]", g), 32'(cyc), 32'(mon_cyc));
        end
      end
    end
    if (!track_occ) max_occ = 0;
    else if (32'(outstanding_v[0]) > max_occ) max_occ = 32'(outstanding_v[0]);
  end

  // ---------------- driver ----------------
  // Presents one request on dut g and holds it until accepted. At the
  // handshake the RAM port is checked and the expected response is queued.
  // Called and returns at posedge+1.
  task automatic do_req(input int g, input logic w, input logic [1:0] sz,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] exp_wen, input logic [31:0] exp_rd,
                        input int exp_lat, input int max_wait, output int hs_cyc);
    logic seen = 1'b0;
    hs_cyc     = -1;
    req_v[g]   = 1'b1;
    wr_v[g]    = w;
    size_v[g]  = sz;
    addr_v[g]  = a;
    wdata_v[g] = wd;
    for (int k = 0; k < max_wait && !seen; k++) begin
      @(negedge clk);
      if (addr_ok_v[g] === 1'b1) begin
        seen   = 1'b1;
        hs_cyc = cyc;
        check("ram_en", {31'b0, ram_en_v[g]}, 32'h1);
        check("ram_wen", {28'b0, ram_wen_v[g]}, {28'b0, exp_wen});
        check("ram_addr", ram_addr_v[g], {a[31:2], 2'b00});
        exp_q.push_back(exp_rd);
        exp_cyc_q.push_back((exp_lat < 0) ? -1 : cyc + exp_lat);
      end
      @(posedge clk);
      #1;
    end
    req_v[g] = 1'b0;
    check("handshake_seen", {31'b0, seen}, 32'h1);
  endtask

  task automatic drain(input int max_cyc);
    int k = 0;
    while (exp_q.size() != 0 && k < max_cyc) begin
      @(posedge clk);
      k++;
    end
    check("drain_empty", 32'(exp_q.size()), 32'h0);
    exp_q.delete();
    exp_cyc_q.delete();
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  int          h0, h1, h2, h3, s;
  logic [31:0] ra;

  initial begin
    for (int g = 0; g < N; g++) begin
      req_v[g]   = 1'b0;
      wr_v[g]    = 1'b0;
      size_v[g]  = 2'd0;
      addr_v[g]  = 32'h0;
      wdata_v[g] = 32'h0;
    end
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    req_v[0] = 1'b1;
    @(negedge clk);
    check("rst_addr_ok_with_req", {31'b0, addr_ok_v[0]}, 32'h0);
    for (int g = 0; g < N; g++) begin
      check($sformatf("rst_data_ok[%0d]", g), {31'b0, data_ok_v[g]}, 32'h0);
      check($sformatf("rst_rdata[%0d]", g), rdata_v[g], 32'h0);
      check($sformatf("rst_ram_en[%0d]", g), {31'b0, ram_en_v[g]}, 32'h0);
      check($sformatf("rst_ram_wen[%0d]", g), {28'b0, ram_wen_v[g]}, 32'h0);
      check($sformatf("rst_outstanding[%0d]", g), {29'b0, outstanding_v[g]}, 32'h0);
    end
    @(posedge clk);
    #1;
    req_v[0] = 1'b0;
    reset    = 1'b0;
    @(posedge clk);
    #1;

    // Single read: accept at once, data_ok two cycles later.
    s = cyc;
    do_req(0, 1'b0, 2'd2, 32'h0000_1000, 32'h0, 4'h0, 32'h2408_0001, 2, 10, h0);
    check("t1_accept_latency", 32'(h0 - s), 32'h0);
    drain(20);

    // Back-to-back reads: one accept per cycle, occupancy peaks at 2.
    track_occ = 1'b1;
    do_req(0, 1'b0, 2'd2, 32'h0000_0000, 32'h0, 4'h0, 32'h9E37_0000, 2, 10, h0);
    do_req(0, 1'b0, 2'd2, 32'h0000_0004, 32'h0, 4'h0, 32'h9E33_0004, 2, 10, h1);
    do_req(0, 1'b0, 2'd2, 32'h0000_0008, 32'h0, 4'h0, 32'h9E3F_0008, 2, 10, h2);
    do_req(0, 1'b0, 2'd2, 32'h0000_000C, 32'h0, 4'h0, 32'h9E3B_000C, 2, 10, h3);
    check("t2_back_to_back", 32'(h3 - h0), 32'h3);
    drain(20);
    check("t2_max_outstanding", 32'(max_occ), 32'h2);
    track_occ = 1'b0;

    // Full stall on DEPTH 2 with DATA_OK_DELAY 3: third accept waits for
    // the first pop at T+5, so it lands at T+6; responses at T+5, T+9, T+13.
    do_req(1, 1'b0, 2'd2, 32'h0000_0100, 32'h0, 4'h0, 32'h9F37_0100, 5, 10, h0);
    do_req(1, 1'b0, 2'd2, 32'h0000_0104, 32'h0, 4'h0, 32'h9F33_0104, 8, 10, h1);
    do_req(1, 1'b0, 2'd2, 32'h0000_0108, 32'h0, 4'h0, 32'h9F3F_0108, 7, 20, h2);
    check("t3_third_accept", 32'(h2 - h0), 32'h6);
    drain(30);

    // Byte and half writes, then word reads of the modified words.
    do_req(0, 1'b1, 2'd0, 32'h0000_2003, 32'hABAB_ABAB, 4'b1000, 32'h0, 2, 10, h0);
    do_req(0, 1'b0, 2'd2, 32'h0000_2000, 32'h0, 4'h0, 32'hAB37_2000, 2, 10, h1);
    do_req(0, 1'b1, 2'd1, 32'h0000_2006, 32'h1234_1234, 4'b1100, 32'h0, 2, 10, h2);
    do_req(0, 1'b0, 2'd3, 32'h0000_2004, 32'h0, 4'h0, 32'h1234_2004, 2, 10, h3);
    drain(20);

    // Address delay 2: accept two cycles after req rises.
    s = cyc;
    do_req(2, 1'b0, 2'd2, 32'h0000_0200, 32'h0, 4'h0, 32'h9C37_0200, 2, 10, h0);
    check("t5_addr_delay", 32'(h0 - s), 32'h2);
    drain(20);
    // A one-cycle req then a gap restarts the count.
    req_v[2]  = 1'b1;
    addr_v[2] = 32'h0000_0204;
    @(negedge clk);
    check("t5_early_addr_ok", {31'b0, addr_ok_v[2]}, 32'h0);
    @(posedge clk);
    #1;
    req_v[2] = 1'b0;
    @(negedge clk);
    check("t5_idle_addr_ok", {31'b0, addr_ok_v[2]}, 32'h0);
    @(posedge clk);
    #1;
    s = cyc;
    do_req(2, 1'b0, 2'd2, 32'h0000_0204, 32'h0, 4'h0, 32'h9C33_0204, 2, 10, h0);
    check("t5_restart_delay", 32'(h0 - s), 32'h2);
    drain(20);

    // Random handshake jitter: 100 reads checked for order and data.
    for (int i = 0; i < 100; i++) begin
      ra = 32'h4000 + (32'($urandom_range(0, 4095)) << 2);
      do_req(3, 1'b0, 2'd2, ra, 32'h0, 4'h0, pat(ra), -1, 200, h0);
    end
    drain(1000);

    // Reset with two requests outstanding: they are dropped silently.
    do_req(1, 1'b0, 2'd2, 32'h0000_0300, 32'h0, 4'h0, 32'h9D37_0300, -1, 10, h0);
    do_req(1, 1'b0, 2'd2, 32'h0000_0304, 32'h0, 4'h0, 32'h9D33_0304, -1, 10, h1);
    @(negedge clk);
    check("t6_outstanding_before_reset", {29'b0, outstanding_v[1]}, 32'h2);
    @(posedge clk);
    #1;
    reset = 1'b1;
    exp_q.delete();
    exp_cyc_q.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    for (int g = 0; g < N; g++)
      check($sformatf("t6_outstanding_after_reset[%0d]", g), {29'b0, outstanding_v[g]}, 32'h0);
    repeat (12) @(posedge clk);
    #1;
    check("final_queue_empty", 32'(exp_q.size()), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
